// File: rtl/prog_mem_loadable_pkg.sv
// prog_mem_loadable_pkg: loader state encodings and byte/word sizing shared by the program memory.
package prog_mem_loadable_pkg;

    typedef enum logic [1:0] {LD_IDLE, LD_LEN, LD_DATA, LD_DONE} ld_state_e;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/prog_ram_dp.sv
// prog_ram_dp: one-write/one-read synchronous RAM; the array itself is never reset.
module prog_ram_dp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    // Addresses past the populated depth read as zero.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rdata_q <= '0;
        else if (re_i) rdata_q <= (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem_loadable.sv
// prog_mem_loadable: program RAM with a length-prefixed byte-stream loader that holds the CPU while writing.
module prog_mem_loadable
    import prog_mem_loadable_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err,
    output logic              cpu_hold
);
    localparam int BYTES_PER_WORD = bytes_per_word(DATA_W);
    localparam int BCW = $clog2(BYTES_PER_WORD) + 1;

    ld_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, cnt_q, cnt_d, wptr_q, wptr_d;
    logic [BCW-1:0]    bcnt_q, bcnt_d;
    logic              err_q, err_d, fvalid_q;
    logic              accept, last_byte, we;
    logic [DATA_W-1:0] word;

    assign accept      = load_valid && load_ready;
    assign last_byte   = bcnt_q == BCW'(BYTES_PER_WORD - 1);
    // MSB-first assembly: the newest byte always lands in the low lane.
    assign word        = DATA_W'({shift_q, load_byte});
    assign load_ready  = state_q inside {LD_LEN, LD_DATA};
    assign cpu_hold    = state_q != LD_IDLE;
    assign load_done   = state_q == LD_DONE;
    assign load_err    = err_q;
    assign fetch_valid = fvalid_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        bcnt_d  = bcnt_q;
        err_d   = 1'b0;
        we      = 1'b0;
        if (accept) begin
            shift_d = word;
            bcnt_d  = last_byte ? '0 : bcnt_q + BCW'(1);
        end
        case (state_q)
            LD_IDLE: if (load_start) begin
                state_d = LD_LEN;
                bcnt_d  = '0;
            end
            LD_LEN: if (accept && last_byte) begin
                cnt_d  = word;
                wptr_d = '0;
                if (word == '0) state_d = LD_DONE;
                else if (64'(word) > 64'(DEPTH)) begin
                    state_d = LD_IDLE;
                    err_d   = 1'b1;
                end else state_d = LD_DATA;
            end
            LD_DATA: if (accept && last_byte) begin
                we     = 1'b1;
                wptr_d = wptr_q + DATA_W'(1);
                if (wptr_q == cnt_q - DATA_W'(1)) state_d = LD_DONE;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= LD_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            bcnt_q   <= '0;
            err_q    <= 1'b0;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            bcnt_q   <= bcnt_d;
            err_q    <= err_d;
            fvalid_q <= fetch_en && !cpu_hold;
        end

    prog_ram_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we),
        .waddr_i (ADDR_W'(wptr_q)),
        .wdata_i (word),
        .re_i    (fetch_en && !cpu_hold),
        .raddr_i (fetch_addr),
        .rdata_o (fetch_data)
    );

endmodule
